// File: rtl/ac_word_seq.sv
// ac_word_seq: drives one external 4-bit arithmetic circuit (d = a + y + cin)
// nibble by nibble, LSB first, to perform 4*NIBBLES-bit add/sub/inc/dec/transfer.
// Command and response use valid/ready handshakes; the inter-nibble carry is
// held in a register between cycles.
// Optional feature: define AC_WORD_SEQ_OVF_EN to add the rsp_overflow output
// (two's-complement overflow of the full-width result).
module ac_word_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_d,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
`ifdef AC_WORD_SEQ_OVF_EN
    output logic                   rsp_overflow,
`endif
    output logic [3:0]             ac_a,
    output logic [3:0]             ac_b,
    output logic                   ac_s1,
    output logic                   ac_s0,
    output logic                   ac_cin,
    input  logic [3:0]             ac_d,
    input  logic                   ac_carry
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_d;
    logic            r_zero;
    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_a_nibs [NIBBLES];
    logic [3:0]      w_b_nibs [NIBBLES];
    logic [W-1:0]    w_d_next;

    // Split operands into nibble slices and merge the current AC sum into the result word
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign w_a_nibs[gi]         = r_a[4*gi +: 4];
            assign w_b_nibs[gi]         = r_b[4*gi +: 4];
            assign w_d_next[4*gi +: 4]  = (r_idx == IDXW'(gi)) ? ac_d : r_d[4*gi +: 4];
        end
    endgenerate

    assign rsp_d     = r_d;
    assign rsp_carry = r_carry;   // after the last nibble this is the MSB carry-out
    assign rsp_zero  = r_zero;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake / AC drive outputs (AC lines idle at 0 outside RUN)
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        ac_a         = 4'd0;
        ac_b         = 4'd0;
        ac_s1        = 1'b0;
        ac_s0        = 1'b0;
        ac_cin       = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                ac_a           = w_a_nibs[r_idx];
                ac_b           = w_b_nibs[r_idx];
                {ac_s1, ac_s0} = r_op[2:1];
                ac_cin         = (r_idx == '0) ? r_op[0] : r_carry;
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef AC_WORD_SEQ_OVF_EN
    logic r_ovf;
    logic w_y_msb;

    // MSB of the AC's y operand for the final nibble, chosen by {s1,s0}
    always_comb begin
        case (r_op[2:1])
            2'b00:   w_y_msb = r_b[W-1];
            2'b01:   w_y_msb = ~r_b[W-1];
            2'b10:   w_y_msb = 1'b0;
            default: w_y_msb = 1'b1;
        endcase
    end

    assign rsp_overflow = r_ovf;
`endif

    // Datapath: latch the command, then one nibble per RUN cycle with chained carry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op    <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_zero  <= 1'b0;
`ifdef AC_WORD_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_idx <= '0;
            end
            if (r_state == S_RUN) begin
                r_d     <= w_d_next;
                r_carry <= ac_carry;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    // Flags are registered alongside the final slice so they never glitch in DONE
                    r_zero <= (w_d_next == '0);
`ifdef AC_WORD_SEQ_OVF_EN
                    r_ovf  <= (r_a[W-1] == w_y_msb) && (ac_d[3] != r_a[W-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ac_word_seq.sv
// Testbench for ac_word_seq: behavioural 4-bit AC attached to the DUT, a word-level
// reference model compared every cycle, directed literal cases and random traffic.
module tb_ac_word_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_d;
    logic          rsp_carry;
    logic          rsp_zero;
    logic          ovf_sig;
    logic [3:0]    ac_a;
    logic [3:0]    ac_b;
    logic          ac_s1;
    logic          ac_s0;
    logic          ac_cin;
    logic [3:0]    ac_d;
    logic          ac_carry;
    logic [3:0]    ac_y;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit rand_mode = 1'b0;

    always #5 clk = ~clk;

    ac_word_seq #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
`ifdef AC_WORD_SEQ_OVF_EN
        .rsp_overflow(ovf_sig),
`endif
        .ac_a(ac_a), .ac_b(ac_b), .ac_s1(ac_s1), .ac_s0(ac_s0), .ac_cin(ac_cin),
        .ac_d(ac_d), .ac_carry(ac_carry)
    );

`ifndef AC_WORD_SEQ_OVF_EN
    assign ovf_sig = 1'b0;
`endif

    // External 4-bit arithmetic circuit
    always_comb begin
        case ({ac_s1, ac_s0})
            2'b00:   ac_y = ac_b;
            2'b01:   ac_y = ~ac_b;
            2'b10:   ac_y = 4'h0;
            default: ac_y = 4'hF;
        endcase
    end
    assign {ac_carry, ac_d} = 5'(ac_a) + 5'(ac_y) + 5'(ac_cin);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---- word-level reference ----
    function automatic logic [W-1:0] y_of(input logic [2:0] op, input logic [W-1:0] b);
        case (op[2:1])
            2'b00:   return b;
            2'b01:   return ~b;
            2'b10:   return '0;
            default: return '1;
        endcase
    endfunction

    function automatic logic [W:0] sum_of(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, y_of(op, b)} + {{W{1'b0}}, op[0]};
    endfunction

    // carry entering nibble k = carry out of the low 4k bits of the full sum
    function automatic logic cin_into(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input int k);
        logic [W-1:0] m;
        logic [W:0]   t;
        if (k == 0) return op[0];
        m = '0;
        for (int i = 0; i < 4*k; i++) m[i] = 1'b1;
        t = {1'b0, a & m} + {1'b0, y_of(op, b) & m} + {{W{1'b0}}, op[0]};
        return t[4*k];
    endfunction

    function automatic logic ovf_of(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        logic [W-1:0] y;
        logic [W:0]   s;
        y = y_of(op, b);
        s = sum_of(op, a, b);
        return (a[W-1] == y[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Timing model: 0 idle, 1..NIB = RUN cycle for nibble (phase-1), NIB+1 = response held
    int           m_phase = 0;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (cmd_valid) begin
                m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
                m_phase = 1;
            end
        end else if (m_phase <= NIB) begin
            m_phase++;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [W:0] s;
        int k;
        if (chk_en) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(m_phase == 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == NIB + 1));
            if (m_phase >= 1 && m_phase <= NIB) begin
                k = m_phase - 1;
                chk("ac_a", 64'(ac_a), 64'(m_a[4*k +: 4]));
                chk("ac_b", 64'(ac_b), 64'(m_b[4*k +: 4]));
                chk("ac_sel", 64'({ac_s1, ac_s0}), 64'(m_op[2:1]));
                chk("ac_cin", 64'(ac_cin), 64'(cin_into(m_op, m_a, m_b, k)));
            end else begin
                chk("ac_idle", 64'({ac_a, ac_b, ac_s1, ac_s0, ac_cin}), 64'(0));
            end
            if (m_phase == NIB + 1) begin
                s = sum_of(m_op, m_a, m_b);
                chk("rsp_d", 64'(rsp_d), 64'(s[W-1:0]));
                chk("rsp_carry", 64'(rsp_carry), 64'(s[W]));
                chk("rsp_zero", 64'(rsp_zero), 64'(s[W-1:0] == '0));
`ifdef AC_WORD_SEQ_OVF_EN
                chk("rsp_overflow", 64'(ovf_sig), 64'(ovf_of(m_op, m_a, m_b)));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Present a command and wait (bounded) until it is accepted
    task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = 1'b1; break; end
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_op = 3'($urandom);
    endtask

    // Directed transaction: returns values seen after holding the response for 'hold' cycles
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, output logic [W-1:0] d, output logic c,
                           output logic z, output logic o, output int lat);
        bit got;
        rsp_ready = 1'b0;
        send_cmd(op, a, b);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin got = 1'b1; break; end
        end
        if (!got) chk("rsp_timeout", 64'(got), 64'(1));
        repeat (hold) @(negedge clk);
        d = rsp_d; c = rsp_carry; z = rsp_zero; o = ovf_sig;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn op=%0d a=%h b=%h -> d=%h carry=%0d zero=%0d ovf=%0d lat=%0d",
                 op, a, b, d, c, z, o, lat);
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int hold, input logic [W-1:0] ed,
                            input logic ec, input logic ez);
        logic [W-1:0] d; logic c, z, o; int lat;
        run_cmd(op, a, b, hold, d, c, z, o, lat);
        chk({name, "_d"}, 64'(d), 64'(ed));
        chk({name, "_carry"}, 64'(c), 64'(ec));
        chk({name, "_zero"}, 64'(z), 64'(ez));
        chk({name, "_latency"}, 64'(lat), 64'(NIB + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d; logic c, z, o; int lat;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_d", 64'(rsp_d), 64'(0));
        chk("reset_flags", 64'({rsp_carry, rsp_zero, ovf_sig}), 64'(0));
        chk("reset_ac", 64'({ac_a, ac_b, ac_s1, ac_s0, ac_cin}), 64'(0));
        @(posedge clk); #1;

        directed("add",     3'b000, 16'h1234, 16'h0FFF, 0, 16'h2233, 1'b0, 1'b0);
        directed("sub_brw", 3'b011, 16'h0005, 16'h0007, 0, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ok",  3'b011, 16'h0007, 16'h0005, 0, 16'h0002, 1'b1, 1'b0);
        directed("inc",     3'b101, 16'hFFFF, 16'h1357, 0, 16'h0000, 1'b1, 1'b1);
        directed("dec",     3'b110, 16'h0000, 16'h0000, 0, 16'hFFFF, 1'b0, 1'b0);
        directed("xfer_c1", 3'b111, 16'h1234, 16'hABCD, 0, 16'h1234, 1'b1, 1'b0);
        directed("addc",    3'b001, 16'h0FFE, 16'h0001, 0, 16'h1000, 1'b0, 1'b0);
        // Response held off for 10 cycles; per-cycle checks cover stability meanwhile
        directed("bp",      3'b000, 16'h00FF, 16'h0001, 10, 16'h0100, 1'b0, 1'b0);
        directed("after_bp",3'b010, 16'h1000, 16'h0FFF, 0, 16'h0000, 1'b1, 1'b1);

        // Reset during the second RUN cycle aborts the command
        rsp_ready = 1'b1;
        send_cmd(3'b000, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_run_rsp_d", 64'(rsp_d), 64'(0));
        for (int i = 0; i < NIB + 3; i++) begin
            chk("rst_run_no_rsp", 64'(rsp_valid), 64'(0));
            @(negedge clk);
        end
        $display("txn reset mid-RUN: no response produced");
        rsp_ready = 1'b0;
        @(posedge clk); #1;

`ifdef AC_WORD_SEQ_OVF_EN
        run_cmd(3'b000, 16'h7FFF, 16'h0001, 0, d, c, z, o, lat);
        chk("ovf_add_d", 64'(d), 64'(16'h8000));
        chk("ovf_add", 64'(o), 64'(1));
        run_cmd(3'b011, 16'h8000, 16'h0001, 0, d, c, z, o, lat);
        chk("ovf_sub_d", 64'(d), 64'(16'h7FFF));
        chk("ovf_sub", 64'(o), 64'(1));
        run_cmd(3'b000, 16'h1234, 16'h0001, 0, d, c, z, o, lat);
        chk("ovf_none", 64'(o), 64'(0));
`endif

        // Random traffic with random response backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [W-1:0] a, b;
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                default: b = W'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_cmd(op, a, b);
            $display("txn rand op=%0d a=%h b=%h expect=%h", op, a, b, sum_of(op, a, b));
        end
        repeat (3 * NIB) @(negedge clk);
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        repeat (NIB + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
